mesi_multiline_snoop_ctrl: RTL and testbench

//  Next-generation MESI controller: holds state for NUM_LINES cache lines (not one),

---
 rtl/mesi_multiline_snoop_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mesi_multiline_snoop_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_multiline_snoop_ctrl.sv
// mesi_multiline_snoop_ctrl
//   MESI coherence controller tracking NUM_LINES cache lines. CPU reads and
//   writes go through a registered IDLE/BUS_WAIT/RESP request FSM with a bus
//   request/grant handshake. Snoops from other caches are serviced every cycle
//   regardless of FSM state.
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   cpu_req_valid/ready/type/idx     CPU request handshake (type RD/WR)
//   cpu_resp_valid, cpu_resp_hit     one-cycle completion pulse, hit flag
//   bus_req_valid/type/idx           pending bus transaction, held until bus_gnt
//   bus_gnt, bus_shared_i            grant and shared indication from the bus
//   snoop_valid/type/idx             remote transaction observed this cycle
//   snoop_shared_o, snoop_flush_o    line present / dirty data supplied
//   line_state_o                     state of line[cpu_req_idx]
//   hit_cnt, miss_cnt, inval_cnt     saturating statistics counters
module mesi_multiline_snoop_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req_valid,
    output logic             cpu_req_ready,
    input  logic [1:0]       cpu_req_type,
    input  logic [IDX_W-1:0] cpu_req_idx,
    output logic             cpu_resp_valid,
    output logic             cpu_resp_hit,
    output logic             bus_req_valid,
    output logic [1:0]       bus_req_type,
    output logic [IDX_W-1:0] bus_req_idx,
    input  logic             bus_gnt,
    input  logic             bus_shared_i,
    input  logic             snoop_valid,
    input  logic [1:0]       snoop_type,
    input  logic [IDX_W-1:0] snoop_idx,
    output logic             snoop_shared_o,
    output logic             snoop_flush_o,
    output logic [1:0]       line_state_o,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] inval_cnt
);

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_E = 2'b10;
    localparam logic [1:0] ST_M = 2'b11;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    localparam logic [1:0] FSM_IDLE     = 2'b00;
    localparam logic [1:0] FSM_BUS_WAIT = 2'b01;
    localparam logic [1:0] FSM_RESP     = 2'b10;

    logic [1:0]       line_q [NUM_LINES];
    logic [1:0]       line_d [NUM_LINES];
    logic [1:0]       fsm_q;
    logic [1:0]       pend_type_q;
    logic [IDX_W-1:0] pend_idx_q;
    logic             resp_hit_q;

    logic [1:0]       cur_state;
    logic [1:0]       snp_state;
    logic             accept;
    logic             req_hit;
    logic             grant;
    logic             snoop_inval;

    // Remote transaction effect on one line.
    function automatic logic [1:0] snoop_next(input logic [1:0] st, input logic [1:0] typ);
        logic [1:0] nxt;
        nxt = st;
        if (typ == OP_RD && (st == ST_M || st == ST_E))
            nxt = ST_S;
        else if (typ == OP_WR)
            nxt = ST_I;
        return nxt;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign cur_state      = line_q[cpu_req_idx];
    assign snp_state      = line_q[snoop_idx];
    assign line_state_o   = cur_state;
    assign snoop_shared_o = snoop_valid && (snp_state != ST_I);
    assign snoop_flush_o  = snoop_valid && (snp_state == ST_M);
    assign snoop_inval    = snoop_valid && (snoop_type == OP_WR) && (snp_state != ST_I);

    assign cpu_req_ready  = (fsm_q == FSM_IDLE);
    // Only the two legal request encodings are accepted.
    assign accept         = cpu_req_valid && cpu_req_ready &&
                            (cpu_req_type == OP_RD || cpu_req_type == OP_WR);
    assign req_hit        = (cpu_req_type == OP_RD) ? (cur_state != ST_I)
                                                    : (cur_state == ST_E || cur_state == ST_M);
    assign grant          = (fsm_q == FSM_BUS_WAIT) && bus_gnt;

    assign bus_req_valid  = (fsm_q == FSM_BUS_WAIT);
    assign bus_req_type   = bus_req_valid ? pend_type_q : OP_NOP;
    assign bus_req_idx    = pend_idx_q;
    assign cpu_resp_valid = (fsm_q == FSM_RESP);
    assign cpu_resp_hit   = cpu_resp_valid && resp_hit_q;

    // Snoop is applied first and our own update overrides it on the same
    // line: our transaction is ordered after the remote one.
    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            line_d[i] = line_q[i];
            if (snoop_valid && snoop_idx == IDX_W'(i))
                line_d[i] = snoop_next(line_q[i], snoop_type);
            if (accept && req_hit && cpu_req_type == OP_WR && cpu_req_idx == IDX_W'(i))
                line_d[i] = ST_M;
            if (grant && pend_idx_q == IDX_W'(i))
                line_d[i] = (pend_type_q == OP_WR) ? ST_M : (bus_shared_i ? ST_S : ST_E);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++)
                line_q[i] <= ST_I;
        end else begin
            for (int i = 0; i < NUM_LINES; i++)
                line_q[i] <= line_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= FSM_IDLE;
            pend_type_q <= OP_NOP;
            pend_idx_q  <= '0;
            resp_hit_q  <= 1'b0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            inval_cnt   <= '0;
        end else begin
            if (snoop_inval)
                inval_cnt <= sat_inc(inval_cnt);
            case (fsm_q)
                FSM_IDLE: begin
                    if (accept) begin
                        resp_hit_q <= req_hit;
                        if (req_hit) begin
                            hit_cnt <= sat_inc(hit_cnt);
                            fsm_q   <= FSM_RESP;
                        end else begin
                            miss_cnt    <= sat_inc(miss_cnt);
                            pend_type_q <= cpu_req_type;
                            pend_idx_q  <= cpu_req_idx;
                            fsm_q       <= FSM_BUS_WAIT;
                        end
                    end
                end
                FSM_BUS_WAIT: begin
                    if (bus_gnt)
                        fsm_q <= FSM_RESP;
                end
                FSM_RESP: fsm_q <= FSM_IDLE;
                default:  fsm_q <= FSM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesi_multiline_snoop_ctrl.sv
module tb_mesi_multiline_snoop_ctrl;
    localparam logic [1:0] I = 2'b00, S = 2'b01, E = 2'b10, M = 2'b11;
    localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [1:0]  cpu_req_type;
    logic [3:0]  cpu_req_idx;
    logic        cpu_resp_valid;
    logic        cpu_resp_hit;
    logic        bus_req_valid;
    logic [1:0]  bus_req_type;
    logic [3:0]  bus_req_idx;
    logic        bus_gnt;
    logic        bus_shared_i;
    logic        snoop_valid;
    logic [1:0]  snoop_type;
    logic [3:0]  snoop_idx;
    logic        snoop_shared_o;
    logic        snoop_flush_o;
    logic [1:0]  line_state_o;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic [15:0] inval_cnt;

    mesi_multiline_snoop_ctrl #(.NUM_LINES(16), .IDX_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_type(cpu_req_type), .cpu_req_idx(cpu_req_idx),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit),
        .bus_req_valid(bus_req_valid), .bus_req_type(bus_req_type), .bus_req_idx(bus_req_idx),
        .bus_gnt(bus_gnt), .bus_shared_i(bus_shared_i),
        .snoop_valid(snoop_valid), .snoop_type(snoop_type), .snoop_idx(snoop_idx),
        .snoop_shared_o(snoop_shared_o), .snoop_flush_o(snoop_flush_o),
        .line_state_o(line_state_o),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .inval_cnt(inval_cnt)
    );

    always #5 clk = ~clk;

    int         total  = 0;
    int         passed = 0;
    bit         exp_q[$];
    logic [1:0] mdl [16];
    int         m_hit, m_miss, m_inval;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = I;
        m_hit = 0; m_miss = 0; m_inval = 0;
        exp_q.delete();
    endtask

    // Full CPU transaction; assumes entry at a falling edge with FSM idle.
    task automatic cpu_txn(input logic [1:0] t, input logic [3:0] idx, input int gnt_delay,
                           input logic shared, input string nm);
        bit eh;
        bit got;
        eh = (t == RD) ? (mdl[idx] != I) : (mdl[idx] == E || mdl[idx] == M);
        exp_q.push_back(eh);
        cpu_req_valid = 1'b1; cpu_req_type = t; cpu_req_idx = idx;
        #1;
        total++;
        if (cpu_req_ready !== 1'b1) $display("FAIL %s_ready got=%0b want=1", nm, cpu_req_ready);
        else passed++;
        @(negedge clk);
        cpu_req_valid = 1'b0; cpu_req_type = NOP;
        if (eh) begin
            m_hit++;
            if (t == WR) mdl[idx] = M;
            total++;
            if (bus_req_valid !== 1'b0) $display("FAIL %s_no_busreq got=%0b want=0", nm, bus_req_valid);
            else passed++;
        end else begin
            m_miss++;
            for (int k = 0; k <= gnt_delay; k++) begin
                total++;
                if (bus_req_valid !== 1'b1 || bus_req_type !== t || bus_req_idx !== idx)
                    $display("FAIL %s_busreq cyc%0d got=%0b/%0d/%0d want=1/%0d/%0d",
                             nm, k, bus_req_valid, bus_req_type, bus_req_idx, t, idx);
                else passed++;
                if (k == gnt_delay) begin bus_gnt = 1'b1; bus_shared_i = shared; end
                @(negedge clk);
            end
            bus_gnt = 1'b0; bus_shared_i = 1'b0;
            mdl[idx] = (t == WR) ? M : (shared ? S : E);
        end
        total++;
        if (cpu_resp_valid !== 1'b1) $display("FAIL %s_resp_valid got=%0b want=1", nm, cpu_resp_valid);
        else passed++;
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            total++;
            if (cpu_resp_hit !== got) $display("FAIL %s_resp_hit got=%0b want=%0b", nm, cpu_resp_hit, got);
            else passed++;
        end
        #1;
        total++;
        if (line_state_o !== mdl[idx]) $display("FAIL %s_line got=%0d want=%0d", nm, line_state_o, mdl[idx]);
        else passed++;
        total++;
        if (hit_cnt !== 16'(m_hit) || miss_cnt !== 16'(m_miss))
            $display("FAIL %s_counters got=%0d/%0d want=%0d/%0d", nm, hit_cnt, miss_cnt, m_hit, m_miss);
        else passed++;
        @(negedge clk);
        total++;
        if (cpu_resp_valid !== 1'b0) $display("FAIL %s_resp_one_cycle got=%0b want=0", nm, cpu_resp_valid);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus_req_valid !== 1'b0 || bus_req_type !== NOP || cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b1)
            $display("FAIL reset_outputs got=%0b/%0d/%0b/%0b want=0/0/0/1",
                     bus_req_valid, bus_req_type, cpu_resp_valid, cpu_req_ready);
        else passed++;
        total++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || inval_cnt !== 16'd0)
            $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", hit_cnt, miss_cnt, inval_cnt);
        else passed++;
        for (int i = 0; i < 16; i += 5) begin
            cpu_req_idx = 4'(i);
            #1;
            total++;
            if (line_state_o !== I) $display("FAIL reset_line%0d got=%0d want=0", i, line_state_o);
            else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        cpu_txn(RD, 4'd3, 0, 1'b0, "rd_miss3");
    endtask

    task automatic test_write_hit();
        cpu_txn(WR, 4'd3, 0, 1'b0, "wr_hit3");
    endtask

    task automatic test_snoop();
        snoop_valid = 1'b1; snoop_type = RD; snoop_idx = 4'd3;
        #1;
        total++;
        if (snoop_shared_o !== 1'b1 || snoop_flush_o !== 1'b1)
            $display("FAIL snoop_rd_M got=%0b/%0b want=1/1", snoop_shared_o, snoop_flush_o);
        else passed++;
        @(negedge clk);
        mdl[3] = S;
        snoop_type = WR;
        #1;
        total++;
        if (snoop_shared_o !== 1'b1 || snoop_flush_o !== 1'b0)
            $display("FAIL snoop_wr_S got=%0b/%0b want=1/0", snoop_shared_o, snoop_flush_o);
        else passed++;
        @(negedge clk);
        mdl[3] = I; m_inval++;
        snoop_valid = 1'b0; snoop_type = NOP;
        cpu_req_idx = 4'd3;
        #1;
        total++;
        if (line_state_o !== I || inval_cnt !== 16'(m_inval))
            $display("FAIL snoop_inval got=%0d/%0d want=0/%0d", line_state_o, inval_cnt, m_inval);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_upgrade_wait();
        cpu_txn(RD, 4'd5, 0, 1'b1, "rd_shared5");
        cpu_txn(WR, 4'd5, 3, 1'b0, "upg5_wait4");
    endtask

    // Line 5 is M here; a remote read demotes it to S, then an upgrade is
    // invalidated by a remote write while it waits for the bus.
    task automatic test_upgrade_snooped();
        bit got;
        snoop_valid = 1'b1; snoop_type = RD; snoop_idx = 4'd5;
        @(negedge clk);
        mdl[5] = S;
        snoop_valid = 1'b0;
        exp_q.push_back(1'b0);
        cpu_req_valid = 1'b1; cpu_req_type = WR; cpu_req_idx = 4'd5;
        @(negedge clk);
        cpu_req_valid = 1'b0; cpu_req_type = NOP; m_miss++;
        snoop_valid = 1'b1; snoop_type = WR; snoop_idx = 4'd5;
        @(negedge clk);
        snoop_valid = 1'b0; mdl[5] = I; m_inval++;
        #1;
        total++;
        if (line_state_o !== I || inval_cnt !== 16'(m_inval) || bus_req_valid !== 1'b1 ||
            bus_req_type !== WR || bus_req_idx !== 4'd5)
            $display("FAIL upg_snooped_pending got=%0d/%0d/%0b/%0d/%0d want=0/%0d/1/2/5",
                     line_state_o, inval_cnt, bus_req_valid, bus_req_type, bus_req_idx, m_inval);
        else passed++;
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0; mdl[5] = M;
        got = exp_q.pop_front();
        #1;
        total++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_hit !== got || line_state_o !== M)
            $display("FAIL upg_snooped_resp got=%0b/%0b/%0d want=1/%0b/3",
                     cpu_resp_valid, cpu_resp_hit, line_state_o, got);
        else passed++;
        @(negedge clk);
    endtask

    // WR miss on tgt granted on the same edge as a remote write to snp.
    task automatic collide(input logic [3:0] tgt, input logic [3:0] snp, input string nm);
        bit got;
        exp_q.push_back(1'b0);
        cpu_req_valid = 1'b1; cpu_req_type = WR; cpu_req_idx = tgt;
        @(negedge clk);
        cpu_req_valid = 1'b0; cpu_req_type = NOP; m_miss++;
        bus_gnt = 1'b1;
        snoop_valid = 1'b1; snoop_type = WR; snoop_idx = snp;
        @(negedge clk);
        bus_gnt = 1'b0; snoop_valid = 1'b0; snoop_type = NOP;
        if (mdl[snp] != I) m_inval++;
        mdl[snp] = I;
        mdl[tgt] = M;
        got = exp_q.pop_front();
        total++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_hit !== got)
            $display("FAIL %s_resp got=%0b/%0b want=1/%0b", nm, cpu_resp_valid, cpu_resp_hit, got);
        else passed++;
        cpu_req_idx = tgt;
        #1;
        total++;
        if (line_state_o !== mdl[tgt]) $display("FAIL %s_tgt got=%0d want=%0d", nm, line_state_o, mdl[tgt]);
        else passed++;
        cpu_req_idx = snp;
        #1;
        total++;
        if (line_state_o !== mdl[snp] || inval_cnt !== 16'(m_inval))
            $display("FAIL %s_snp got=%0d/%0d want=%0d/%0d", nm, line_state_o, inval_cnt, mdl[snp], m_inval);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_collision();
        cpu_txn(RD, 4'd2, 0, 1'b0, "rd_miss2");
        collide(4'd7, 4'd7, "coll_same7");
        collide(4'd9, 4'd2, "coll_diff9_2");
    endtask

    task automatic test_back_to_back();
        cpu_txn(RD, 4'd1, 1, 1'b0, "b2b_rd_miss1");
        cpu_txn(RD, 4'd1, 0, 1'b0, "b2b_rd_hit1");
        cpu_txn(WR, 4'd1, 0, 1'b0, "b2b_wr_hit1");
        cpu_txn(RD, 4'd9, 0, 1'b0, "b2b_rd_hitM9");
    endtask

    task automatic test_reset_mid();
        int seen;
        cpu_req_valid = 1'b1; cpu_req_type = WR; cpu_req_idx = 4'd11;
        @(negedge clk);
        cpu_req_valid = 1'b0; cpu_req_type = NOP;
        total++;
        if (bus_req_valid !== 1'b1) $display("FAIL rstmid_pending got=%0b want=1", bus_req_valid);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus_req_valid !== 1'b0 || cpu_resp_valid !== 1'b0)
            $display("FAIL rstmid_async got=%0b/%0b want=0/0", bus_req_valid, cpu_resp_valid);
        else passed++;
        for (int i = 1; i < 16; i += 2) begin
            cpu_req_idx = 4'(i);
            #1;
            total++;
            if (line_state_o !== I) $display("FAIL rstmid_line%0d got=%0d want=0", i, line_state_o);
            else passed++;
        end
        total++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || inval_cnt !== 16'd0)
            $display("FAIL rstmid_counters got=%0d/%0d/%0d want=0/0/0", hit_cnt, miss_cnt, inval_cnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (cpu_resp_valid !== 1'b0 || bus_req_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL rstmid_no_resp got=%0d active cycles want=0", seen);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        cpu_req_valid = 1'b0; cpu_req_type = NOP; cpu_req_idx = '0;
        bus_gnt = 1'b0; bus_shared_i = 1'b0;
        snoop_valid = 1'b0; snoop_type = NOP; snoop_idx = '0;
        model_reset();
        test_reset();
        test_read_miss();
        test_write_hit();
        test_snoop();
        test_upgrade_wait();
        test_upgrade_snooped();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
